// File: rtl/l1_miss_fill_ctrl.sv
// l1_miss_fill_ctrl: miss/fill controller below the L1 4-way cache.
// Read misses fetch the word from backing memory and present it for one cycle
// on fill_data_o so the L1 allocates it. Every write is written through to
// memory. Optional feature macro: MISS_TIMEOUT_EN (REQ watchdog, sticky err_o).
module l1_miss_fill_ctrl #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] SENTINEL       = 32'hDEADBEEF,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter int unsigned           CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [3:0]            byte_en_i,
  input  logic                  l1_cache_hit_i,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_byte_en_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  we_q;
  logic                  wr_hit_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;
  logic                  rd_miss_c;
  logic                  start_c;

`ifdef MISS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
  logic            to_hit_c;
  assign to_hit_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Transfer start: read that missed the L1, or any write
  assign rd_miss_c = rd_en_i & ~l1_cache_hit_i;
  assign start_c   = rd_miss_c | wr_en_i;

  // Controller FSM with latched access and registered memory/fill outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      wr_hit_q   <= 1'b0;
      req_q      <= 1'b0;
      fill_q     <= SENTINEL;
      miss_cnt_q <= '0;
`ifdef MISS_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            addr_q   <= addr_i;
            wdata_q  <= wr_data_i;
            be_q     <= byte_en_i;
            we_q     <= wr_en_i;
            wr_hit_q <= wr_en_i & l1_cache_hit_i;
            req_q    <= 1'b1;
            state_q  <= ST_REQ;
`ifdef MISS_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
            if (rd_miss_c && !wr_en_i && (miss_cnt_q != '1)) begin
              miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            req_q <= 1'b0;
            if (wr_hit_q) begin
              state_q <= ST_IDLE;
            end else begin
              fill_q  <= we_q ? wdata_q : mem_rdata_i;
              state_q <= ST_FILL;
            end
          end
`ifdef MISS_TIMEOUT_EN
          else if (to_hit_c) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        ST_FILL: begin
          fill_q  <= SENTINEL;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          fill_q  <= SENTINEL;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational so the CPU sees it in the cycle the miss appears
  assign stall_o = rst_n & ((state_q == ST_IDLE && start_c) || (state_q != ST_IDLE));

  assign fill_data_o   = fill_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_byte_en_o = be_q;
  assign miss_cnt_o    = miss_cnt_q;

`ifdef MISS_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l1_miss_fill_ctrl.sv
// Directed self-checking bench for l1_miss_fill_ctrl (CNT_WIDTH=4, TIMEOUT_CYCLES=8).
module tb_l1_miss_fill_ctrl;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en, hit, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] fill_data, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_we, err;
  logic [3:0]  mem_be, miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l1_miss_fill_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SENTINEL(32'hDEADBEEF),
    .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en_i(rd_en), .wr_en_i(wr_en), .addr_i(addr), .wr_data_i(wdata),
    .byte_en_i(be), .l1_cache_hit_i(hit),
    .fill_data_o(fill_data), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_byte_en_o(mem_be),
    .mem_ack_i(ack), .mem_rdata_i(rdata),
    .miss_cnt_o(miss_cnt), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Read miss with ack in cycle 1; checks fill word in cycle 2 and hit in cycle 3
  task automatic read_miss(input logic [31:0] a, input logic [31:0] d);
    rd_en = 1'b1; hit = 1'b0; addr = a; ack = 1'b0;
    next_cyc();
    ack = 1'b1; rdata = d;
    next_cyc();
    ack = 1'b0;
    @(negedge clk);
    chk("sat_fill", fill_data, d);
    next_cyc();
    hit = 1'b1;
    @(negedge clk);
    chk("sat_stall_off", 32'(stall), 32'd0);
    next_cyc();
    rd_en = 1'b0; hit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; hit = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; rdata = '0; be = 4'b1111;

    // Reset state
    @(negedge clk);
    chk("rst_fill", fill_data, SENT);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Read miss at 0x104, ack in cycle 1
    rd_en = 1'b1; hit = 1'b0; addr = 32'h0000_0104;
    @(negedge clk);
    chk("rm_c0_stall", 32'(stall), 32'd1);
    chk("rm_c0_req", 32'(mem_req), 32'd0);
    chk("rm_c0_fill", fill_data, SENT);
    next_cyc();
    ack = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rm_c1_stall", 32'(stall), 32'd1);
    chk("rm_c1_req", 32'(mem_req), 32'd1);
    chk("rm_c1_we", 32'(mem_we), 32'd0);
    chk("rm_c1_addr", mem_addr, 32'h0000_0104);
    chk("rm_c1_cnt", 32'(miss_cnt), 32'd1);
    chk("rm_c1_fill", fill_data, SENT);
    next_cyc();
    ack = 1'b0; rdata = 32'h0;
    @(negedge clk);
    chk("rm_c2_stall", 32'(stall), 32'd1);
    chk("rm_c2_fill", fill_data, 32'h1234_5678);
    chk("rm_c2_req", 32'(mem_req), 32'd0);
    next_cyc();
    hit = 1'b1;
    @(negedge clk);
    chk("rm_c3_stall", 32'(stall), 32'd0);
    chk("rm_c3_fill", fill_data, SENT);
    chk("rm_c3_req", 32'(mem_req), 32'd0);
    next_cyc();
    rd_en = 1'b0; hit = 1'b0;
    next_cyc();

    // Write hit at 0x40, ack in cycle 4
    wr_en = 1'b1; hit = 1'b1; addr = 32'h40; wdata = 32'hA5A5_A5A5; be = 4'b1111;
    @(negedge clk);
    chk("wh_c0_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      if (c == 4) ack = 1'b1;
      @(negedge clk);
      chk("wh_req", 32'(mem_req), 32'd1);
      chk("wh_stall", 32'(stall), 32'd1);
      chk("wh_fill", fill_data, SENT);
    end
    chk("wh_we", 32'(mem_we), 32'd1);
    chk("wh_addr", mem_addr, 32'h40);
    chk("wh_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("wh_be", 32'(mem_be), 32'hF);
    next_cyc();
    ack = 1'b0; wr_en = 1'b0; hit = 1'b0;
    @(negedge clk);
    chk("wh_c5_stall", 32'(stall), 32'd0);
    chk("wh_c5_req", 32'(mem_req), 32'd0);
    chk("wh_c5_fill", fill_data, SENT);
    next_cyc();
    @(negedge clk);
    chk("wh_c6_req", 32'(mem_req), 32'd0);
    chk("wh_c6_fill", fill_data, SENT);
    chk("wh_cnt", 32'(miss_cnt), 32'd1);
    next_cyc();

    // Write miss at 0x80, byte enable 0011: written word is presented as fill
    wr_en = 1'b1; hit = 1'b0; addr = 32'h80; wdata = 32'h0BAD_F00D; be = 4'b0011;
    next_cyc();
    ack = 1'b1; rdata = 32'h1111_1111;
    @(negedge clk);
    chk("wm_be", 32'(mem_be), 32'h3);
    chk("wm_we", 32'(mem_we), 32'd1);
    next_cyc();
    ack = 1'b0;
    @(negedge clk);
    chk("wm_fill", fill_data, 32'h0BAD_F00D);
    chk("wm_stall", 32'(stall), 32'd1);
    next_cyc();
    wr_en = 1'b0; be = 4'b1111;
    @(negedge clk);
    chk("wm_idle_stall", 32'(stall), 32'd0);
    chk("wm_cnt", 32'(miss_cnt), 32'd1);
    next_cyc();

    // Reset while in REQ, ack arrives during reset
    rd_en = 1'b1; hit = 1'b0; addr = 32'h200;
    next_cyc();
    @(negedge clk);
    chk("mr_req_before", 32'(mem_req), 32'd1);
    next_cyc();
    rst_n = 1'b0; ack = 1'b1; rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_fill", fill_data, SENT);
    chk("mr_cnt", 32'(miss_cnt), 32'd0);
    next_cyc();
    rst_n = 1'b1; ack = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("mr_post_fill", fill_data, SENT);
    chk("mr_post_req", 32'(mem_req), 32'd0);
    chk("mr_post_stall", 32'(stall), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("mr_post2_fill", fill_data, SENT);
    next_cyc();

    // Memory never acknowledges
    rd_en = 1'b1; hit = 1'b0; addr = 32'h300;
`ifdef MISS_TIMEOUT_EN
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      if (c >= 9) rd_en = 1'b0;
      @(negedge clk);
      chk("to_req", 32'(mem_req), (c <= 8) ? 32'd1 : 32'd0);
      chk("to_err", 32'(err), (c <= 8) ? 32'd0 : 32'd1);
    end
    next_cyc();
`else
    for (int c = 1; c <= 105; c++) begin
      next_cyc();
      @(negedge clk);
      chk("hang_req", 32'(mem_req), 32'd1);
      chk("hang_stall", 32'(stall), 32'd1);
    end
    chk("hang_err", 32'(err), 32'd0);
    next_cyc();
    ack = 1'b1; rdata = 32'hCAFE_0300;
    next_cyc();
    ack = 1'b0;
    @(negedge clk);
    chk("hang_fill", fill_data, 32'hCAFE_0300);
    next_cyc();
    hit = 1'b1;
    @(negedge clk);
    chk("hang_done_stall", 32'(stall), 32'd0);
    next_cyc();
    rd_en = 1'b0; hit = 1'b0;
    next_cyc();
`endif

    // Miss counter saturation at 4 bits
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    for (int n = 1; n <= 20; n++) begin
      read_miss(32'h1000 + 32'(n * 4), 32'h7000_0000 + 32'(n));
      if (n == 3)  chk("sat_cnt3", 32'(miss_cnt), 32'd3);
      if (n == 15) chk("sat_cnt15", 32'(miss_cnt), 32'd15);
    end
    @(negedge clk);
    chk("sat_cnt20", 32'(miss_cnt), 32'd15);
    chk("sat_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
